traffic_light_controller_param: RTL and testbench



---
 rtl/traffic_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 31 +++
 rtl/traffic_light_controller_param.sv | 150 +++++++++++++++
 tb/tb_traffic_light_controller_param.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection controller: lamp codes,
// phase type and the elaboration-time duration clamp.
package traffic_pkg;

  // Per-direction lamp triplet {green, yellow, red}
  localparam logic [2:0] LAMP_GRN = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_RED = 3'b001;

  typedef enum logic {
    PH_GREEN  = 1'b0,
    PH_YELLOW = 1'b1
  } phase_e;

  // A zero-second phase would never be visible, so it is stretched to one second.
  function automatic int clamp_dur(input int d);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second tick generator: counts clk cycles 0..TICK_DIV-1 and flags the
// last cycle of each period. TICK_DIV=1 yields a tick every cycle.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int               L_DIV  = (TICK_DIV < 1) ? 1 : TICK_DIV;
  localparam int               CNT_W  = (L_DIV > 1) ? $clog2(L_DIV) : 1;
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(L_DIV - 1);

  logic [CNT_W-1:0] r_tick_cnt;

  // Cycle counter that wraps at the end of each one-second period
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == L_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_tick_cnt == L_LAST);

endmodule

// File: rtl/traffic_light_controller_param.sv
// Parametrised N-way traffic light controller. Serves NUM_DIR approaches in
// cyclic order, each with a GREEN then YELLOW phase, timed in seconds from a
// clk prescaler. mode selects uniform (0) or major/minor (1) green timing and
// is only sampled when a green phase is loaded.
// Optional build macro TLC_SKIP_IDLE_EN adds a req input so the next green
// goes to the first requesting direction after the current one.
module traffic_light_controller_param
  import traffic_pkg::*;
#(
  parameter int NUM_DIR     = 4,
  parameter int TICK_DIV    = 50_000_000,
  parameter int GREEN_MAJOR = 120,
  parameter int GREEN_MINOR = 50,
  parameter int GREEN_UNI   = 50,
  parameter int YELLOW      = 10,
  parameter int SEC_W       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mode,
`ifdef TLC_SKIP_IDLE_EN
  input  logic [NUM_DIR-1:0]         req,
`endif
  output logic [3*NUM_DIR-1:0]       lightout,
  output logic [$clog2(NUM_DIR)-1:0] phase_dir,
  output logic                       phase_yellow,
  output logic [SEC_W-1:0]           sec_left
);

  localparam int DIR_W = $clog2(NUM_DIR);

  // Values loaded into the seconds counter (duration minus one)
  localparam logic [SEC_W-1:0] L_LOAD_MAJOR = SEC_W'(clamp_dur(GREEN_MAJOR) - 1);
  localparam logic [SEC_W-1:0] L_LOAD_MINOR = SEC_W'(clamp_dur(GREEN_MINOR) - 1);
  localparam logic [SEC_W-1:0] L_LOAD_UNI   = SEC_W'(clamp_dur(GREEN_UNI) - 1);
  localparam logic [SEC_W-1:0] L_LOAD_YEL   = SEC_W'(clamp_dur(YELLOW) - 1);
  localparam logic [DIR_W-1:0] L_LAST_DIR   = DIR_W'(NUM_DIR - 1);

  // Green counter load for a direction under the given timing mode
  function automatic logic [SEC_W-1:0] green_load(input logic [DIR_W-1:0] dir,
                                                  input logic             md);
    if (!md) begin
      return L_LOAD_UNI;
    end
    return dir[0] ? L_LOAD_MINOR : L_LOAD_MAJOR;
  endfunction

  phase_e           r_ph;
  logic [DIR_W-1:0] r_dir;
  logic [DIR_W-1:0] r_nxt;
  logic [SEC_W-1:0] r_sec;

  phase_e           w_ph_nxt;
  logic [DIR_W-1:0] w_dir_nxt;
  logic [DIR_W-1:0] w_nxt_nxt;
  logic [SEC_W-1:0] w_sec_nxt;
  logic [DIR_W-1:0] w_succ;
  logic [3*NUM_DIR-1:0] w_light;
  logic             w_tick;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

`ifdef TLC_SKIP_IDLE_EN
  logic [DIR_W-1:0] w_cand;
  logic             w_found;

  // Successor: first requesting direction after the current one, cyclically
  // (wrapping onto itself); plain successor when nobody is waiting
  always_comb begin
    w_succ  = (r_dir == L_LAST_DIR) ? '0 : r_dir + DIR_W'(1);
    w_found = 1'b0;
    w_cand  = r_dir;
    for (int k = 0; k < NUM_DIR; k++) begin
      w_cand = (w_cand == L_LAST_DIR) ? '0 : w_cand + DIR_W'(1);
      if (!w_found && req[w_cand]) begin
        w_succ  = w_cand;
        w_found = 1'b1;
      end
    end
  end
`else
  // Successor: strict cyclic order
  always_comb begin
    w_succ = (r_dir == L_LAST_DIR) ? '0 : r_dir + DIR_W'(1);
  end
`endif

  // State register: phase, owning direction, latched successor, seconds left
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph  <= PH_GREEN;
      r_dir <= '0;
      r_nxt <= '0;
      r_sec <= green_load('0, mode);
    end else begin
      r_ph  <= w_ph_nxt;
      r_dir <= w_dir_nxt;
      r_nxt <= w_nxt_nxt;
      r_sec <= w_sec_nxt;
    end
  end

  // Next state: count seconds down on each tick, change phase when exhausted
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_ph_nxt  = r_ph;
    w_dir_nxt = r_dir;
    w_nxt_nxt = r_nxt;
    w_sec_nxt = r_sec;
    if (w_tick) begin
      if (r_sec != '0) begin
        w_sec_nxt = r_sec - SEC_W'(1);
      end else if (r_ph == PH_GREEN) begin
        w_ph_nxt  = PH_YELLOW;
        w_nxt_nxt = w_succ;
        w_sec_nxt = L_LOAD_YEL;
      end else begin
        w_ph_nxt  = PH_GREEN;
        w_dir_nxt = r_nxt;
        w_sec_nxt = green_load(r_nxt, mode);
      end
    end
  end

  // Lamp decode: owner green, or owner and successor yellow; everyone else red
  always_comb begin
    w_light = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      if (r_ph == PH_GREEN && r_dir == DIR_W'(d)) begin
        w_light[3*(NUM_DIR-1-d) +: 3] = LAMP_GRN;
      end else if (r_ph == PH_YELLOW && (r_dir == DIR_W'(d) || r_nxt == DIR_W'(d))) begin
        w_light[3*(NUM_DIR-1-d) +: 3] = LAMP_YEL;
      end else begin
        w_light[3*(NUM_DIR-1-d) +: 3] = LAMP_RED;
      end
    end
  end

  assign lightout     = w_light;
  assign phase_dir    = r_dir;
  assign phase_yellow = (r_ph == PH_YELLOW);
  assign sec_left     = r_sec;

endmodule

// File: tb/tb_traffic_light_controller_param.sv
// Self-checking bench for traffic_light_controller_param (4 directions,
// 2-cycle seconds). A phase-level reference model runs alongside every test.
`timescale 1ns/1ps
module tb_traffic_light_controller_param;

  localparam int NUM_DIR     = 4;
  localparam int TICK_DIV    = 2;
  localparam int GREEN_MAJOR = 6;
  localparam int GREEN_MINOR = 3;
  localparam int GREEN_UNI   = 4;
  localparam int YELLOW      = 2;
  localparam int SEC_W       = 8;

  logic                   clk  = 1'b0;
  logic                   rst  = 1'b1;
  logic                   mode = 1'b0;
  logic [NUM_DIR-1:0]     req  = '0;
  logic [3*NUM_DIR-1:0]   lightout;
  logic [1:0]             phase_dir;
  logic                   phase_yellow;
  logic [SEC_W-1:0]       sec_left;

  traffic_light_controller_param #(
    .NUM_DIR     (NUM_DIR),
    .TICK_DIV    (TICK_DIV),
    .GREEN_MAJOR (GREEN_MAJOR),
    .GREEN_MINOR (GREEN_MINOR),
    .GREEN_UNI   (GREEN_UNI),
    .YELLOW      (YELLOW),
    .SEC_W       (SEC_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
`ifdef TLC_SKIP_IDLE_EN
    .req          (req),
`endif
    .lightout     (lightout),
    .phase_dir    (phase_dir),
    .phase_yellow (phase_yellow),
    .sec_left     (sec_left)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (phase level) ----------------
  int m_dir, m_nxt, m_c, m_d;
  bit m_yel;

  function automatic int green_secs(input int dir, input bit md);
    if (!md) return GREEN_UNI;
    return (dir % 2 == 0) ? GREEN_MAJOR : GREEN_MINOR;
  endfunction

  // First requesting direction after dir (cyclic, may be dir itself), else dir+1
  function automatic int pick_next(input int dir, input logic [NUM_DIR-1:0] r);
    for (int k = 1; k <= NUM_DIR; k++)
      if (r[(dir + k) % NUM_DIR]) return (dir + k) % NUM_DIR;
    return (dir + 1) % NUM_DIR;
  endfunction

  function automatic logic [3*NUM_DIR-1:0] exp_light(input int dir, input bit yel, input int nxt);
    logic [3*NUM_DIR-1:0] v;
    v = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      if (!yel && d == dir)               v[3*(NUM_DIR-1-d) +: 3] = 3'b100;
      else if (yel && (d == dir || d == nxt)) v[3*(NUM_DIR-1-d) +: 3] = 3'b010;
      else                                v[3*(NUM_DIR-1-d) +: 3] = 3'b001;
    end
    return v;
  endfunction

  // Advance the model by one clock: a phase of D seconds spans D*TICK_DIV cycles
  task automatic model_step();
    if (rst) begin
      m_dir = 0; m_yel = 0; m_nxt = 0; m_c = 0;
      m_d = green_secs(0, mode);
    end else begin
      m_c++;
      if (m_c == m_d * TICK_DIV) begin
        m_c = 0;
        if (!m_yel) begin
          m_yel = 1;
          m_nxt = pick_next(m_dir, req);
          m_d   = YELLOW;
        end else begin
          m_yel = 0;
          m_dir = m_nxt;
          m_d   = green_secs(m_dir, mode);
        end
      end
    end
  endtask

  task automatic compare_model();
    int n_grn;
    bit both;
    check("model_light", lightout, exp_light(m_dir, m_yel, m_nxt));
    check("model_dir", phase_dir, m_dir);
    check("model_yellow", phase_yellow, m_yel);
    check("model_sec", sec_left, m_d - 1 - m_c / TICK_DIV);
    n_grn = 0;
    both  = 0;
    for (int d = 0; d < NUM_DIR; d++) begin
      if (lightout[3*d+2]) n_grn++;
      if (lightout[3*d+2] && lightout[3*d+1]) both = 1;
    end
    check("inv_single_green", (n_grn <= 1), 1);
    check("inv_green_and_yellow", both, 0);
  endtask

  // One clock: model follows the same edge, outputs compared on the falling edge
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset(input bit md);
    rst  = 1'b1;
    mode = md;
    cyc();
    rst  = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int          delta;
    logic [11:0] light;
    int          dir;
    bit          yel;
    int          sec;
  } vec_t;

  vec_t tbl [11];
  int   glen_exp [4];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int len;
    // mode=0 sequence: green 8 cycles, yellow 4 cycles, dirs 0..3 then back
    tbl[0]  = '{0, 12'b100_001_001_001, 0, 1'b0, 3};
    tbl[1]  = '{7, 12'b100_001_001_001, 0, 1'b0, 0};
    tbl[2]  = '{1, 12'b010_010_001_001, 0, 1'b1, 1};
    tbl[3]  = '{3, 12'b010_010_001_001, 0, 1'b1, 0};
    tbl[4]  = '{1, 12'b001_100_001_001, 1, 1'b0, 3};
    tbl[5]  = '{8, 12'b001_010_010_001, 1, 1'b1, 1};
    tbl[6]  = '{4, 12'b001_001_100_001, 2, 1'b0, 3};
    tbl[7]  = '{8, 12'b001_001_010_010, 2, 1'b1, 1};
    tbl[8]  = '{4, 12'b001_001_001_100, 3, 1'b0, 3};
    tbl[9]  = '{8, 12'b010_001_001_010, 3, 1'b1, 1};
    tbl[10] = '{4, 12'b100_001_001_001, 0, 1'b0, 3};
    glen_exp = '{12, 6, 12, 6};

    // Test 1: uniform timing, full rotation
    do_reset(1'b0);
    for (int i = 0; i < 11; i++) begin
      repeat (tbl[i].delta) cyc();
      check("tbl_light", lightout, tbl[i].light);
      check("tbl_dir", phase_dir, tbl[i].dir);
      check("tbl_yellow", phase_yellow, tbl[i].yel);
      check("tbl_sec", sec_left, tbl[i].sec);
    end

    // Test 2: major/minor timing, measure each green and yellow length
    do_reset(1'b1);
    for (int d = 0; d < NUM_DIR; d++) begin
      check("m1_green_dir", phase_dir, d);
      len = 0;
      while (!phase_yellow && len < 100) begin cyc(); len++; end
      check("m1_green_len", len, glen_exp[d]);
      len = 0;
      while (phase_yellow && len < 100) begin cyc(); len++; end
      check("m1_yellow_len", len, 4);
    end

    // Test 3: mode change mid-green does not affect the running phase
    do_reset(1'b0);
    repeat (3) cyc();
    mode = 1'b1;
    repeat (4) cyc();
    check("tog_g0_still_green", phase_yellow, 0);
    cyc();
    check("tog_g0_ends_at_8", phase_yellow, 1);
    repeat (4) cyc();
    check("tog_g1_dir", phase_dir, 1);
    check("tog_g1_sec", sec_left, 2);
    repeat (5) cyc();
    check("tog_g1_still_green", phase_yellow, 0);
    cyc();
    check("tog_g1_len_6", phase_yellow, 1);

    // Test 4: reset pulse during YELLOW(2)
    mode = 1'b0;
    do_reset(1'b0);
    repeat (33) cyc();
    check("rst_in_y2_yellow", phase_yellow, 1);
    check("rst_in_y2_dir", phase_dir, 2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_light", lightout, 12'b100_001_001_001);
    check("rst_dir", phase_dir, 0);
    check("rst_sec", sec_left, 3);
    repeat (8) cyc();
    check("rst_restart_yellow_at_8", phase_yellow, 1);

`ifdef TLC_SKIP_IDLE_EN
    // Test 5: only dir3 requesting, then request dropped
    req = 4'b1000;
    do_reset(1'b0);
    repeat (8) cyc();
    check("skip_y0_light", lightout, 12'b010_001_001_010);
    repeat (4) cyc();
    check("skip_g3_light", lightout, 12'b001_001_001_100);
    check("skip_g3_dir", phase_dir, 3);
    repeat (8) cyc();
    check("skip_y3_only_light", lightout, 12'b001_001_001_010);
    repeat (4) cyc();
    check("skip_g3_again_light", lightout, 12'b001_001_001_100);
    check("skip_g3_again_dir", phase_dir, 3);
    cyc();
    req = '0;
    repeat (7) cyc();
    check("skip_y3_to_0_light", lightout, 12'b010_001_001_010);
    repeat (4) cyc();
    check("skip_back_g0_light", lightout, 12'b100_001_001_001);
    check("skip_back_g0_dir", phase_dir, 0);
`endif

    // Test 6: random mode/reset/request activity against the model
    do_reset(1'($urandom_range(0, 1)));
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      rst = ($urandom_range(0, 199) == 0);
`ifdef TLC_SKIP_IDLE_EN
      if ($urandom_range(0, 19) == 0) req = 4'($urandom_range(0, 15));
`endif
      cyc();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
